// File: rtl/echo_capture_if.sv
// Trigger/ADC inputs and capture-result outputs of the ultrasonic echo receiver.
// The master drives trigger, samples and threshold; the slave publishes the results.
interface echo_capture_if;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 16;

    logic          trig;
    logic [DW-1:0] adc_data;
    logic [DW-1:0] thresh;
    logic          busy;
    logic          done;
    logic          echo_found;
    logic [TW-1:0] tof;
    logic [DW-1:0] peak;
    logic [TW-1:0] peak_pos;
    logic          overrun;

    modport master (
        output trig, adc_data, thresh,
        input  busy, done, echo_found, tof, peak, peak_pos, overrun
    );

    modport slave (
        input  trig, adc_data, thresh,
        output busy, done, echo_found, tof, peak, peak_pos, overrun
    );
endinterface

// File: rtl/echo_capture.sv
// Echo capture: on each trigger edge, blank ring-down, then find first threshold crossing and peak.
// Optional 4-sample moving average on the search sample when ECHO_AVG_EN is defined.
module echo_capture #(
    parameter int unsigned BLANK_CYC = 50,
    parameter int unsigned WIN_CYC   = 20000
) (
    input logic           clk,
    input logic           rst_n,
    echo_capture_if.slave bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYC - 1);
    localparam logic [TW-1:0] WIN_END   = TW'(WIN_CYC - 1);
    localparam logic [TW-1:0] NO_ECHO   = '1;

    typedef enum logic [1:0] {IDLE, BLANK, SEARCH, DONE} state_t;

    state_t        state;
    state_t        state_nx;

    logic          trig_d;
    logic          trig_edge;
    logic          start;
    logic          active;
    logic          win_end;

    logic [DW-1:0] s;
    logic [DW-1:0] thr_q;
    logic [TW-1:0] t;
    logic          found_q;
    logic [TW-1:0] tof_q;
    logic [DW-1:0] peak_q;
    logic [TW-1:0] pos_q;

    logic          found_nx;
    logic [TW-1:0] tof_nx;
    logic [DW-1:0] peak_nx;
    logic [TW-1:0] pos_nx;

    logic          busy_nx;
    logic          done_nx;
    logic          overrun_nx;

    logic          busy_q;
    logic          done_q;
    logic          overrun_q;
    logic          found_o;
    logic [TW-1:0] tof_o;
    logic [DW-1:0] peak_o;
    logic [TW-1:0] pos_o;

    assign trig_edge = bus.trig & ~trig_d;
    assign start     = (state == IDLE) && trig_edge;
    assign active    = (state == BLANK) || (state == SEARCH);
    assign win_end   = (state == SEARCH) && (t == WIN_END);

`ifdef ECHO_AVG_EN
    localparam int unsigned SW = 10;

    logic [2:0][DW-1:0] hist;
    logic [SW-1:0]      sum;

    assign sum = SW'(bus.adc_data) + SW'(hist[0]) + SW'(hist[1]) + SW'(hist[2]);
    assign s   = DW'(sum >> 2);

    // History starts from zero at every capture and keeps filling through blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (start) begin
            hist <= '0;
        end else if (active) begin
            hist <= {hist[1:0], bus.adc_data};
        end
    end
`else
    assign s = bus.adc_data;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nx   = state;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        overrun_nx = 1'b0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    state_nx = BLANK;
                end
            end
            BLANK: begin
                if (t == BLANK_END) begin
                    state_nx = SEARCH;
                end
            end
            SEARCH: begin
                if (t == WIN_END) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx    = (state_nx == BLANK) || (state_nx == SEARCH);
        done_nx    = (state_nx == DONE);
        overrun_nx = trig_edge && (state != IDLE);
    end

    // First crossing and strict-greater peak; ties keep the earliest index.
    always_comb begin
        found_nx = found_q;
        tof_nx   = tof_q;
        peak_nx  = peak_q;
        pos_nx   = pos_q;
        if (state == SEARCH) begin
            if (!found_q && (s >= thr_q)) begin
                found_nx = 1'b1;
                tof_nx   = t;
            end
            if (s > peak_q) begin
                peak_nx = s;
                pos_nx  = t;
            end
        end
    end

    // Capture datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_d  <= 1'b0;
            thr_q   <= '0;
            t       <= '0;
            found_q <= 1'b0;
            tof_q   <= '0;
            peak_q  <= '0;
            pos_q   <= '0;
        end else begin
            trig_d <= bus.trig;
            if (start) begin
                thr_q   <= bus.thresh;
                t       <= '0;
                found_q <= 1'b0;
                tof_q   <= '0;
                peak_q  <= '0;
                pos_q   <= '0;
            end else if (active) begin
                t       <= t + TW'(1);
                found_q <= found_nx;
                tof_q   <= tof_nx;
                peak_q  <= peak_nx;
                pos_q   <= pos_nx;
            end
        end
    end

    // Results load with the final sample folded in, so they are valid alongside done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            found_o   <= 1'b0;
            tof_o     <= '0;
            peak_o    <= '0;
            pos_o     <= '0;
        end else begin
            busy_q    <= busy_nx;
            done_q    <= done_nx;
            overrun_q <= overrun_nx;
            if (win_end) begin
                found_o <= found_nx;
                tof_o   <= found_nx ? tof_nx : NO_ECHO;
                peak_o  <= peak_nx;
                pos_o   <= pos_nx;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;
    assign bus.echo_found = found_o;
    assign bus.tof        = tof_o;
    assign bus.peak       = peak_o;
    assign bus.peak_pos   = pos_o;
endmodule

// File: tb/tb_echo_capture.sv
// Randomized bench for echo_capture against a window-scan reference model.
// Follows ECHO_AVG_EN so the model applies the same 4-sample average as the build.
module tb_echo_capture;
    localparam int unsigned BLANK = 50;
    localparam int unsigned WIN   = 200;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    echo_capture_if bus();

    echo_capture #(.BLANK_CYC(BLANK), .WIN_CYC(WIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int samp [WIN];
    int exp_found, exp_tof, exp_peak, exp_pos;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample seen by the detector at index t (raw, or averaged over a zero-seeded history).
    function automatic int filt(input int t);
`ifdef ECHO_AVG_EN
        int sum = 0;
        for (int k = 0; k < 4; k++) begin
            if (t - k >= 0) sum += samp[t - k];
        end
        return sum / 4;
`else
        return samp[t];
`endif
    endfunction

    function automatic void model(input int thr);
        exp_found = 0;
        exp_tof   = 32'hFFFF;
        exp_peak  = 0;
        exp_pos   = 0;
        for (int t = BLANK; t < WIN; t++) begin
            int v = filt(t);
            if (exp_found == 0 && v >= thr) begin
                exp_found = 1;
                exp_tof   = t;
            end
            if (v > exp_peak) begin
                exp_peak = v;
                exp_pos  = t;
            end
        end
    endfunction

    function automatic void clear_samp();
        for (int t = 0; t < WIN; t++) samp[t] = 0;
    endfunction

    // Starts in an IDLE cycle with trig low; ends in the IDLE cycle after done.
    task automatic capture(input string name, input int thr, input int hold, input int ovr_t);
        int busy_cnt = 0;
        int done_cnt = 0;
        int ovr_cnt  = 0;
        int ovr_at   = -1;
        model(thr);
        bus.trig     = 1'b1;
        bus.thresh   = 8'(thr);
        bus.adc_data = 8'($urandom);
        for (int t = 0; t < int'(WIN); t++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.overrun === 1'b1) begin
                ovr_cnt++;
                ovr_at = t;
            end
            bus.adc_data = 8'(samp[t]);
            bus.thresh   = 8'($urandom);
            if (t == hold - 1) bus.trig = 1'b0;
            if (t == ovr_t) bus.trig = 1'b1;
            if (t == ovr_t + 1) bus.trig = 1'b0;
        end
        @(posedge clk); #1;
        check({name, ".busy_cycles"}, busy_cnt, WIN);
        check({name, ".early_done"}, done_cnt, 0);
        check({name, ".overrun_cnt"}, ovr_cnt, (ovr_t >= 0) ? 1 : 0);
        if (ovr_t >= 0) check({name, ".overrun_at"}, ovr_at, ovr_t + 1);
        check({name, ".done"}, bus.done, 1);
        check({name, ".busy_in_done"}, bus.busy, 0);
        check({name, ".overrun_in_done"}, bus.overrun, 0);
        check({name, ".echo_found"}, bus.echo_found, exp_found);
        check({name, ".tof"}, bus.tof, exp_tof);
        check({name, ".peak"}, bus.peak, exp_peak);
        check({name, ".peak_pos"}, bus.peak_pos, exp_pos);
        @(posedge clk); #1;
        check({name, ".done_cleared"}, bus.done, 0);
        check({name, ".busy_idle"}, bus.busy, 0);
        check({name, ".tof_held"}, bus.tof, exp_tof);
    endtask

    task automatic check_zero(input string name);
        check({name, ".busy"}, bus.busy, 0);
        check({name, ".done"}, bus.done, 0);
        check({name, ".overrun"}, bus.overrun, 0);
        check({name, ".echo_found"}, bus.echo_found, 0);
        check({name, ".tof"}, bus.tof, 0);
        check({name, ".peak"}, bus.peak, 0);
        check({name, ".peak_pos"}, bus.peak_pos, 0);
    endtask

    initial begin
        int thr, hold, ovr;
        int busy_cnt, done_cnt;
        rst_n        = 1'b0;
        bus.trig     = 1'b0;
        bus.adc_data = '0;
        bus.thresh   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        clear_samp();
        samp[80] = 120;
        samp[90] = 200;
        capture("echo", 100, 1, -1);

        clear_samp();
        samp[10] = 255;
        capture("blank", 100, 1, -1);

        clear_samp();
        samp[60]  = 150;
        samp[199] = 150;
        capture("tie", 150, 1, -1);

        clear_samp();
        samp[199] = 150;
        capture("last", 150, 1, -1);

        clear_samp();
        samp[80] = 120;
        samp[90] = 200;
        capture("overrun", 100, 1, 30);

        clear_samp();
        for (int t = BLANK; t < int'(WIN); t++) samp[t] = 100;
        capture("const", 100, 3, -1);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int t = 0; t < int'(WIN); t++) samp[t] = $urandom_range(0, 255);
            end else begin
                for (int t = 0; t < int'(WIN); t++) samp[t] = $urandom_range(0, 40);
                for (int p = 0; p < 4; p++) samp[$urandom_range(0, WIN - 1)] = $urandom_range(60, 255);
            end
            thr  = $urandom_range(50, 255);
            hold = $urandom_range(1, 4);
            ovr  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(hold + 1, WIN - 2);
            capture($sformatf("rand%0d", r), thr, hold, ovr);
        end

        // Reset in the middle of SEARCH must abort silently.
        bus.trig   = 1'b1;
        bus.thresh = 8'd10;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            bus.trig     = 1'b0;
            bus.adc_data = 8'($urandom);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("midreset");
        rst_n    = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int t = 0; t < int'(WIN) + 5; t++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) done_cnt++;
        end
        check("midreset.no_busy", busy_cnt, 0);
        check("midreset.no_done", done_cnt, 0);

        clear_samp();
        samp[150] = 77;
        capture("recover", 70, 2, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/echo_capture.md
# echo_capture

Receive-side counterpart of the ultrasonic transmit trigger. On each rising edge of the transmit trigger the block blanks the transducer ring-down, then searches a window of ADC samples for the first echo crossing a threshold and tracks the peak amplitude and its position. At window end it publishes time-of-flight, peak and a one-cycle `done` strobe for the display/LED and host-readout logic. One capture per trigger; triggers arriving mid-capture are flagged, not queued.

## Interface
Parameters:
- `BLANK_CYC`, 50: cycles after trigger edge during which samples are ignored (1000 ns at 50 MHz).
- `WIN_CYC`, 20000: total capture length in cycles from trigger edge; requires `BLANK_CYC < WIN_CYC <= 65535`.

Ports:
- `clk` input 1: 50 MHz system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `trig` input 1: transmit trigger level from trigger generator, `clk` domain.
- `adc_data` input 8: unsigned echo sample, new value every cycle.
- `thresh` input 8: detection threshold, latched on trigger edge.
- `busy` output 1: capture in progress.
- `done` output 1: one-cycle strobe, results valid.
- `echo_found` output 1: a crossing occurred in the last window.
- `tof` output 16: cycle index of first crossing; 16'hFFFF if none.
- `peak` output 8: maximum sample in search region.
- `peak_pos` output 16: cycle index of `peak`.
- `overrun` output 1: one-cycle strobe, trigger edge ignored while busy.

## Operation
- Edge detect: `trig_d` registers `trig`; edge = `trig & ~trig_d`.
- States: IDLE, BLANK, SEARCH, DONE.
- IDLE: on edge latch `thresh` into `thr_q`, clear `t`, `peak_q`, `pos_q`, `found_q`, → BLANK.
- `t` (16 bit) is 0 in first BLANK cycle, increments every cycle in BLANK/SEARCH.
- BLANK: when `t == BLANK_CYC-1` → SEARCH; samples ignored.
- SEARCH (t = BLANK_CYC .. WIN_CYC-1), sample s = `adc_data` (or filtered value, see Configuration):
  - if `!found_q && s >= thr_q`: `found_q<=1`, `tof_q<=t`.
  - if `s > peak_q`: `peak_q<=s`, `pos_q<=t` (strict: earliest index wins on ties).
  - at `t == WIN_CYC-1` (sample included) → DONE.
- DONE: one cycle; `done=1`; outputs `echo_found/tof/peak/peak_pos` load from internal regs (`tof=16'hFFFF` if not found); → IDLE.
- Outputs hold until next DONE.
- Edge in BLANK/SEARCH/DONE: ignored, `overrun` pulses 1 cycle; capture continues unaffected.
- `peak_pos` is 0 with `peak` 0 if all samples are 0.

## Timing
- Reset (rst_n low at a clk edge): state IDLE, `trig_d=0`, all outputs 0 (`tof=0`, not FFFF), internal regs 0. Reset mid-capture aborts without `done`.
- `trig` high in cycle n with `trig_d` low → BLANK in cycle n+1 (`busy=1` from n+1).
- `busy` high for exactly `WIN_CYC` cycles then DONE cycle; `busy=0` in DONE.
- `done` in cycle n+1+WIN_CYC; edge accepted again from cycle n+2+WIN_CYC (IDLE).
- `t` index equals `adc_data` sampled in that cycle; no pipeline offset without the macro.
- `trig` held high produces only one edge.

## Configuration
- `ECHO_AVG_EN` defined: s = (sum of last 4 `adc_data` samples) >> 2, 10-bit sum, shift register cleared on trigger edge (zeros fill the first 3 samples). Reported indices are the `t` at which the averaged value is evaluated (no latency compensation). Averaging history continues through BLANK.
- Not defined: s = `adc_data` directly; no filter registers.

## Test plan
- Reset: assert `rst_n=0` 3 cycles mid-SEARCH -> all outputs 0, `busy=0`, no `done`.
- Single echo, BLANK_CYC=50, WIN_CYC=200, thresh=100; `adc_data=0` except 120 at t=80, 200 at t=90 -> `done` at n+201, `echo_found=1`, `tof=80`, `peak=200`, `peak_pos=90`.
- Blanking: 255 at t=10, else 0 -> `echo_found=0`, `tof=FFFF`, `peak=0`, `peak_pos=0`.
- Ties and boundary: 150 at t=60 and t=199 (last sample), thresh=150 -> `tof=60`, `peak=150`, `peak_pos=60`; sample at t=199 alone -> `tof=199`.
- Overrun: second `trig` edge at t=30 -> `overrun` one cycle, results identical to single capture; edge 1 cycle after `done` accepted.
- With `ECHO_AVG_EN`: constant 100 from t=50, thresh=100 -> `tof=53`, `peak=100`, `peak_pos=53`.
